// File: rtl/ifu_pkg.sv
// +-----------------------------------------------------------------+
// | ifu_pkg: shared widths and fill FSM state type for the IFU      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package ifu_pkg;

   localparam int ADDR_WIDTH     = 32;
   localparam int OFFSET_WIDTH   = 4;
   localparam int TAG_WIDTH      = ADDR_WIDTH - OFFSET_WIDTH;
   localparam int LINE_WIDTH     = 128;
   localparam int WORD_WIDTH     = 32;
   localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;

   localparam logic [15:0] FILL_COUNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_RESP  = 2'd2,
      ST_HOLD  = 2'd3
   } fill_state_e;

endpackage

`default_nettype wire

// File: rtl/ifu_fill_responder.sv
// +-----------------------------------------------------------------+
// | ifu_fill_responder: fetches a cache line word by word from the  |
// | instruction memory and returns it to the I-cache as one pulse.  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module ifu_fill_responder
   import ifu_pkg::fill_state_e, ifu_pkg::ST_IDLE, ifu_pkg::ST_FETCH,
          ifu_pkg::ST_RESP, ifu_pkg::ST_HOLD;
#(
   parameter int          ADDR_WIDTH     = ifu_pkg::ADDR_WIDTH,
   parameter int          OFFSET_WIDTH   = ifu_pkg::OFFSET_WIDTH,
   parameter int          TAG_WIDTH      = ADDR_WIDTH - OFFSET_WIDTH,
   parameter int          LINE_WIDTH     = ifu_pkg::LINE_WIDTH,
   parameter int          WORD_WIDTH     = ifu_pkg::WORD_WIDTH,
   parameter logic [15:0] FILL_COUNT_MAX = ifu_pkg::FILL_COUNT_MAX
) (
   input  logic                  Clock,
   input  logic                  Rst,
   input  logic [TAG_WIDTH-1:0]  cache_reqTagIn,
   input  logic                  cache_reqTagValidIn,
   output logic [TAG_WIDTH-1:0]  cache_rspTagOut,
   output logic [LINE_WIDTH-1:0] cache_rspInsLineOut,
   output logic                  cache_rspInsLineValidOut,
   output logic                  imem_rdEnOut,
   output logic [ADDR_WIDTH-1:0] imem_rdAddrOut,
   input  logic [WORD_WIDTH-1:0] imem_rdDataIn,
   output logic                  busyOut,
   output logic [15:0]           debug_fillCount
);

   localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
   localparam int IDX_W          = $clog2(WORDS_PER_LINE);
   localparam int CNT_W          = IDX_W + 1;
   localparam int BYTE_W         = OFFSET_WIDTH - IDX_W;

   fill_state_e             state_q;
   logic [TAG_WIDTH-1:0]    reqTag_q;
   logic [CNT_W-1:0]        issueCnt_q;
   logic [IDX_W-1:0]        capCnt_q;
   logic                    rdValid_q;
   logic [LINE_WIDTH-1:0]   line_q;
   logic [LINE_WIDTH-1:0]   line_d;
   logic [TAG_WIDTH-1:0]    rspTag_q;
   logic [LINE_WIDTH-1:0]   rspLine_q;
   logic                    rspValid_q;
   logic                    rdEn_q;
   logic [ADDR_WIDTH-1:0]   rdAddr_q;
   logic [15:0]             fillCount_q;

   // Line buffer with the word returning this cycle merged in, so the last
   // word can go straight into the response register.
   always_comb begin
      line_d = line_q;
      line_d[WORD_WIDTH*int'(capCnt_q) +: WORD_WIDTH] = imem_rdDataIn;
   end

   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         state_q     <= ST_IDLE;
         reqTag_q    <= '0;
         issueCnt_q  <= '0;
         capCnt_q    <= '0;
         rdValid_q   <= 1'b0;
         line_q      <= '0;
         rspTag_q    <= '0;
         rspLine_q   <= '0;
         rspValid_q  <= 1'b0;
         rdEn_q      <= 1'b0;
         rdAddr_q    <= '0;
         fillCount_q <= '0;
      end else begin
         rdValid_q  <= rdEn_q;
         rspValid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               rdEn_q <= 1'b0;
               if (cache_reqTagValidIn) begin
                  // Word 0 is issued on this edge so reads occupy FETCH cycles 1..N.
                  reqTag_q   <= cache_reqTagIn;
                  capCnt_q   <= '0;
                  issueCnt_q <= CNT_W'(1);
                  rdEn_q     <= 1'b1;
                  rdAddr_q   <= {cache_reqTagIn, {IDX_W{1'b0}}, {BYTE_W{1'b0}}};
                  state_q    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (issueCnt_q < CNT_W'(WORDS_PER_LINE)) begin
                  rdEn_q     <= 1'b1;
                  rdAddr_q   <= {reqTag_q, issueCnt_q[IDX_W-1:0], {BYTE_W{1'b0}}};
                  issueCnt_q <= issueCnt_q + CNT_W'(1);
               end else begin
                  rdEn_q <= 1'b0;
               end
               if (rdValid_q) begin
                  line_q   <= line_d;
                  capCnt_q <= capCnt_q + IDX_W'(1);
                  if (capCnt_q == IDX_W'(WORDS_PER_LINE - 1)) begin
                     rspValid_q <= 1'b1;
                     rspTag_q   <= reqTag_q;
                     rspLine_q  <= line_d;
                     state_q    <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               rdEn_q <= 1'b0;
               if (fillCount_q != FILL_COUNT_MAX) begin
                  fillCount_q <= fillCount_q + 16'd1;
               end
               state_q <= ST_HOLD;
            end
            default: begin
               rdEn_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cache_rspTagOut          = rspTag_q;
   assign cache_rspInsLineOut      = rspLine_q;
   assign cache_rspInsLineValidOut = rspValid_q;
   assign imem_rdEnOut             = rdEn_q;
   assign imem_rdAddrOut           = rdAddr_q;
   assign busyOut                  = (state_q != ST_IDLE);
   assign debug_fillCount          = fillCount_q;

endmodule

`default_nettype wire

// File: doc/ifu_fill_responder.md
IFU_FILL_RESPONDER -- requirements
Module: ifu_fill_responder

Interface
REQ-001 SHALL take parameter ADDR_WIDTH, default 32, byte address width (from ifu_pkg).
REQ-002 SHALL take parameter OFFSET_WIDTH, default 4, line offset bits; the line is 16 bytes.
REQ-003 SHALL take parameter TAG_WIDTH, default ADDR_WIDTH-OFFSET_WIDTH (28), line tag width.
REQ-004 SHALL take parameter LINE_WIDTH, default 128, instruction line width.
REQ-005 SHALL take parameter WORD_WIDTH, default 32, backing-memory read width; WORDS_PER_LINE = LINE_WIDTH/WORD_WIDTH (4).
REQ-006 Clock  in  1  clock; all state on rising edge.
REQ-007 Rst  in  1  reset, asynchronous, active-high.
REQ-008 cache_reqTagIn  in  TAG_WIDTH  tag the cache requests.
REQ-009 cache_reqTagValidIn  in  1  level request from the cache, held while the cache misses.
REQ-010 cache_rspTagOut  out  TAG_WIDTH  tag of the returned line.
REQ-011 cache_rspInsLineOut  out  LINE_WIDTH  returned line.
REQ-012 cache_rspInsLineValidOut  out  1  single-cycle line-valid pulse.
REQ-013 imem_rdEnOut  out  1  backing-memory read strobe.
REQ-014 imem_rdAddrOut  out  ADDR_WIDTH  byte address of the word read.
REQ-015 imem_rdDataIn  in  WORD_WIDTH  read data, valid exactly 1 cycle after the strobe.
REQ-016 busyOut  out  1  high in any state other than IDLE.
REQ-017 debug_fillCount  out  16  number of completed fills, saturating.

Function
REQ-018 SHALL implement the FSM IDLE -> FETCH -> RESP -> HOLD -> IDLE.
REQ-019 IDLE: when cache_reqTagValidIn=1, SHALL latch cache_reqTagIn into reqTag, clear the issue and capture counters, and enter FETCH next cycle.
REQ-020 FETCH issue: for issue counter i = 0..WORDS_PER_LINE-1, one read per cycle. Each read drives imem_rdEnOut=1 and imem_rdAddrOut={reqTag, i[1:0], 2'b00}. imem_rdEnOut=0 otherwise.
REQ-021 FETCH capture: a 1-cycle-delayed read-valid flag SHALL write imem_rdDataIn into line bits [WORD_WIDTH*k +: WORD_WIDTH], where k is the capture counter.
REQ-022 The FSM SHALL leave FETCH after capturing word WORDS_PER_LINE-1. FETCH lasts WORDS_PER_LINE+1 cycles.
REQ-023 RESP: for exactly one cycle, cache_rspInsLineValidOut=1, cache_rspTagOut=reqTag, cache_rspInsLineOut=line buffer. debug_fillCount SHALL increment, saturating at 16'hFFFF.
REQ-024 HOLD: one cycle in which the request is ignored, so the cache can register the inserted line and drop the request. Then IDLE.
REQ-025 Latency: request first seen in IDLE at cycle 0 -> reads in cycles 1-4 -> response in cycle 6 -> IDLE in cycle 8.
REQ-026 cache_rspTagOut and cache_rspInsLineOut SHALL hold their last values outside RESP. Only the valid bit qualifies them.
REQ-027 If the request drops or its tag changes during FETCH/RESP, the fill SHALL still complete with the latched tag. There is no abort.
REQ-028 If the request is still high in IDLE after HOLD, a new fill SHALL start, even with the same tag.
REQ-029 A request arriving outside IDLE SHALL NOT be latched.
REQ-030 Tag bits SHALL map straight to address bits [ADDR_WIDTH-1:OFFSET_WIDTH]; the low 2 address bits SHALL always be 0.

Reset
REQ-031 Asserting Rst SHALL clear the following immediately, including mid-FETCH: FSM to IDLE, counters, read-valid flag, reqTag, line buffer, cache_rspInsLineValidOut, imem_rdEnOut, busyOut and debug_fillCount. All other outputs are 0.
REQ-032 After Rst deasserts, a returning read from the aborted fill SHALL NOT be captured. The first request SHALL start a clean fill.

Structure
REQ-033 ADDR_WIDTH, OFFSET_WIDTH, TAG_WIDTH, LINE_WIDTH, WORD_WIDTH, WORDS_PER_LINE and the FSM state enum SHALL live in ifu_pkg.
REQ-034 No sub-module is needed: one module with a sequential FSM, counters and line-buffer registers.

Verification
REQ-035 Test 1: tag 28'h0000010 requested with memory word = address -> reads 0x100, 0x104, 0x108, 0x10C in cycles 1-4; cycle 6 pulse with line {0x10C, 0x108, 0x104, 0x100} and tag 0x0000010.
REQ-036 Test 2: request held through HOLD with the tag unchanged -> a second fill starts in cycle 8 and debug_fillCount reaches 2.
REQ-037 Test 3: tag switches from 0x10 to 0x20 in cycle 2 -> the response carries tag 0x10; the 0x20 fill starts after HOLD.
REQ-038 Test 4: Rst pulse in cycle 3 of a fill -> outputs 0 at once, no response pulse, next fill correct from its start.
REQ-039 Test 5: 65536 back-to-back fills -> debug_fillCount saturates at 16'hFFFF.
REQ-040 Test 6: no request for 100 cycles -> imem_rdEnOut, busyOut and cache_rspInsLineValidOut stay 0.
